// File: rtl/cnn_accel_top.sv
// cnn_accel_top: weight-stationary systolic CNN accelerator (SYS_ROWS x SYS_COLS MACs)
// with constant weight/input ROMs and an IDLE/LOAD_W/STREAM/DRAIN control FSM.
// A start pulse in IDLE loads the weights through a shift-down chain, streams
// NUM_VEC skewed input vectors and presents one de-skewed dot-product vector
// per cycle while ready is high.
//
// Ports:
//   clk     - clock, all logic on the rising edge
//   rst     - asynchronous active-low reset (aborts a run immediately)
//   start   - run request, sampled only in IDLE
//   result  - de-skewed output vector, holds the last vector between runs
//   ready   - result valid this cycle
//
// Build option: define CNN_ACC_SATURATE_EN to clamp every PE accumulation to
// 2^P_BITWIDTH-1 on overflow; otherwise accumulation wraps modulo 2^P_BITWIDTH.
module cnn_accel_top #(
    parameter int unsigned SYS_ROWS   = 6,
    parameter int unsigned SYS_COLS   = 3,
    parameter int unsigned W_BITWIDTH = 8,
    parameter int unsigned I_BITWIDTH = 8,
    parameter int unsigned P_BITWIDTH = 24,
    parameter int unsigned NUM_VEC    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic [SYS_COLS-1:0][P_BITWIDTH-1:0]   result,
    output logic                                  ready
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PROD_W = W_BITWIDTH + I_BITWIDTH;
    localparam int unsigned SUM_W  = ((P_BITWIDTH > PROD_W) ? P_BITWIDTH : PROD_W) + 1;
    // Latency from row-0 injection to the aligned column outputs
    localparam int unsigned VLD_W  = SYS_ROWS + SYS_COLS;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_e;

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;

    logic [W_BITWIDTH-1:0]                w_q [SYS_ROWS][SYS_COLS];
    logic [W_BITWIDTH-1:0]                w_d [SYS_ROWS][SYS_COLS];
    logic [I_BITWIDTH-1:0]                a_q [SYS_ROWS][SYS_COLS];
    logic [I_BITWIDTH-1:0]                a_d [SYS_ROWS][SYS_COLS];
    logic [P_BITWIDTH-1:0]                p_q [SYS_ROWS][SYS_COLS];
    logic [P_BITWIDTH-1:0]                p_d [SYS_ROWS][SYS_COLS];

    logic [I_BITWIDTH-1:0]                row_in  [SYS_ROWS];
    logic [P_BITWIDTH-1:0]                col_out [SYS_COLS];

    logic [VLD_W-1:0]                     vld_q, vld_d;
    logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  result_q, result_d;
    logic                                 ready_q, ready_d;

    logic                                 load_en;
    logic                                 stream_en;

    assign load_en   = (state_q == LOAD_W);
    assign stream_en = (state_q == STREAM);

    // One PE step: partial sum in plus zero-extended product, wrapped or clamped
    function automatic logic [P_BITWIDTH-1:0] mac(
        input logic [P_BITWIDTH-1:0] pin,
        input logic [W_BITWIDTH-1:0] w,
        input logic [I_BITWIDTH-1:0] a
    );
        logic [SUM_W-1:0] prod;
        logic [SUM_W-1:0] sum;
        prod = SUM_W'(w) * SUM_W'(a);
        sum  = SUM_W'(pin) + prod;
`ifdef CNN_ACC_SATURATE_EN
        if (|sum[SUM_W-1:P_BITWIDTH]) begin
            return '1;
        end
`endif
        return P_BITWIDTH'(sum);
    endfunction

    // Control FSM: next state and phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                end
            end
            LOAD_W: begin
                if (cnt_q == CNT_W'(SYS_ROWS - 1)) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STREAM: begin
                if (cnt_q == CNT_W'(NUM_VEC - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Leave once the last vector has been presented
                if (cnt_q == CNT_W'(SYS_ROWS + SYS_COLS)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // PE array next state: weight shift-down, activations right, sums down
    always_comb begin
        w_d = w_q;
        if (load_en) begin
            for (int c = 0; c < int'(SYS_COLS); c++) begin
                // Load edge k feeds ROM row SYS_ROWS-1-k, i.e. W = SYS_ROWS-k+c
                w_d[0][c] = W_BITWIDTH'(32'(SYS_ROWS) + 32'(c) - 32'(cnt_q));
            end
            for (int r = 1; r < int'(SYS_ROWS); r++) begin
                for (int c = 0; c < int'(SYS_COLS); c++) begin
                    w_d[r][c] = w_q[r-1][c];
                end
            end
        end

        for (int r = 0; r < int'(SYS_ROWS); r++) begin
            a_d[r][0] = row_in[r];
            for (int c = 1; c < int'(SYS_COLS); c++) begin
                a_d[r][c] = a_q[r][c-1];
            end
        end

        // Each PE multiplies the activation it is capturing this edge
        for (int c = 0; c < int'(SYS_COLS); c++) begin
            p_d[0][c] = mac('0, w_q[0][c], a_d[0][c]);
        end
        for (int r = 1; r < int'(SYS_ROWS); r++) begin
            for (int c = 0; c < int'(SYS_COLS); c++) begin
                p_d[r][c] = mac(p_q[r-1][c], w_q[r][c], a_d[r][c]);
            end
        end

        vld_d    = {vld_q[VLD_W-2:0], stream_en};
        ready_d  = vld_q[VLD_W-1];
        result_d = result_q;
        if (vld_q[VLD_W-1]) begin
            for (int c = 0; c < int'(SYS_COLS); c++) begin
                result_d[c] = col_out[c];
            end
        end
    end

    // State, PE array and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int r = 0; r < int'(SYS_ROWS); r++) begin
                for (int c = 0; c < int'(SYS_COLS); c++) begin
                    w_q[r][c] <= '0;
                    a_q[r][c] <= '0;
                    p_q[r][c] <= '0;
                end
            end
            vld_q    <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            a_q      <= a_d;
            p_q      <= p_d;
            vld_q    <= vld_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    // Input ROM plus skew: row r passes through r+1 registers
    for (genvar r = 0; r < int'(SYS_ROWS); r++) begin : g_skew
        logic [I_BITWIDTH-1:0] sk_q [0:r];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i <= r; i++) begin
                    sk_q[i] <= '0;
                end
            end else begin
                sk_q[0] <= stream_en ? I_BITWIDTH'(32'(cnt_q) + 32'(r) + 32'd1) : '0;
                for (int i = 1; i <= r; i++) begin
                    sk_q[i] <= sk_q[i-1];
                end
            end
        end

        assign row_in[r] = sk_q[r];
    end

    // Output de-skew: column c delayed SYS_COLS-1-c cycles
    for (genvar c = 0; c < int'(SYS_COLS); c++) begin : g_deskew
        localparam int unsigned DEPTH = SYS_COLS - 1 - c;
        if (DEPTH == 0) begin : g_direct
            assign col_out[c] = p_q[SYS_ROWS-1][c];
        end else begin : g_dly
            logic [P_BITWIDTH-1:0] dl_q [0:DEPTH-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        dl_q[i] <= '0;
                    end
                end else begin
                    dl_q[0] <= p_q[SYS_ROWS-1][c];
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        dl_q[i] <= dl_q[i-1];
                    end
                end
            end

            assign col_out[c] = dl_q[DEPTH-1];
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_cnn_accel_top.sv
// Self-checking bench for cnn_accel_top: default build plus a P_BITWIDTH=6
// instance for the overflow behaviour (CNN_ACC_SATURATE_EN selects clamping).
module tb_cnn_accel_top;

    localparam int T0 = 16;   // first result edge: 2*6 + 3 + 1
    localparam int NV = 4;
    localparam int NR = 6;
    localparam int NC = 3;
`ifdef CNN_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [NC-1:0][23:0]   result;
    logic                  ready;
    logic [NC-1:0][5:0]    result_s;
    logic                  ready_s;

    int errors = 0;
    int checks = 0;

    logic [23:0] gold [NV][NC];
    logic [23:0] held [NC];

    cnn_accel_top dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .result (result),
        .ready  (ready)
    );

    cnn_accel_top #(.P_BITWIDTH(6)) dut_s (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .result (result_s),
        .ready  (ready_s)
    );

    always #5 clk = ~clk;

    // Reference dot product: sum over rows of x_v[r]*W[r][c], wrapped or clamped at pw bits
    function automatic logic [23:0] golden(input int v, input int c, input int pw);
        longint acc;
        longint maxv;
        acc  = 0;
        maxv = (64'd1 << pw) - 1;
        for (int r = 0; r < NR; r++) begin
            acc += longint'((v + r + 1) & 255) * longint'((r + c + 1) & 255);
            if (SAT && acc > maxv) acc = maxv;
            acc = acc & maxv;
        end
        return 24'(acc);
    endfunction

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_value ready=%b result=%h exp ready=0 result=0", ready, result);
        end
        rst = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ready !== 1'b0 || result !== '0 || ready_s !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d ready=%b result=%h exp ready=0 result=0",
                         e, ready, result);
            end
        end
        for (int c = 0; c < NC; c++) held[c] = '0;
    endtask

    // One run from a start pulse; noisy=1 adds random start activity mid-run
    task automatic test_run(input bit noisy);
        logic [23:0] exp;
        bit          exp_rdy;
        int          idx;
        repeat ($urandom_range(0, 4)) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            if (noisy) start = (e == 8) ? 1'b1 : ((e <= 20) ? 1'($urandom_range(0, 1)) : 1'b0);
            @(posedge clk);
            #1;
            exp_rdy = (e >= T0) && (e < T0 + NV);
            checks++;
            if (ready !== exp_rdy) begin
                errors++;
                $display("FAIL run_ready noisy=%0d e=%0d got=%b exp=%b", noisy, e, ready, exp_rdy);
            end
            idx = (e - T0 >= NV) ? NV - 1 : e - T0;
            for (int c = 0; c < NC; c++) begin
                exp = (e < T0) ? held[c] : gold[idx][c];
                checks++;
                if (result[c] !== exp) begin
                    errors++;
                    $display("FAIL run_result noisy=%0d e=%0d c=%0d got=%0d exp=%0d",
                             noisy, e, c, result[c], exp);
                end
            end
            if (e == NR) begin
                for (int r = 0; r < NR; r++) begin
                    for (int c = 0; c < NC; c++) begin
                        checks++;
                        if (dut.w_q[r][c] !== 8'(r + c + 1)) begin
                            errors++;
                            $display("FAIL weight r=%0d c=%0d got=%0d exp=%0d",
                                     r, c, dut.w_q[r][c], r + c + 1);
                        end
                    end
                end
            end
            if (e == T0) begin
                checks++;
                if (result_s[0] !== 6'(golden(0, 0, 6))) begin
                    errors++;
                    $display("FAIL narrow_psum got=%0d exp=%0d", result_s[0], 6'(golden(0, 0, 6)));
                end
            end
        end
        start = 1'b0;
        for (int c = 0; c < NC; c++) held[c] = gold[NV-1][c];
    endtask

    // Reset asserted k edges into a run clears outputs immediately
    task automatic test_mid_reset(input int k);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= k; e++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== '0 || result_s !== '0) begin
            errors++;
            $display("FAIL mid_reset k=%0d ready=%b result=%h exp ready=0 result=0", k, ready, result);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < NC; c++) held[c] = '0;
    endtask

    // start held high: second run begins one IDLE cycle after the first ends
    task automatic test_back_to_back();
        logic [23:0] exp;
        bit          exp_rdy;
        int          idx;
        int          t2;
        t2 = T0 + NV + 1 + T0;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 42; e++) begin
            if (e == 38) start = 1'b0;
            @(posedge clk);
            #1;
            exp_rdy = ((e >= T0) && (e < T0 + NV)) || ((e >= t2) && (e < t2 + NV));
            checks++;
            if (ready !== exp_rdy) begin
                errors++;
                $display("FAIL b2b_ready e=%0d got=%b exp=%b", e, ready, exp_rdy);
            end
            idx = (e >= t2) ? e - t2 : e - T0;
            if (idx >= NV) idx = NV - 1;
            for (int c = 0; c < NC; c++) begin
                exp = (e < T0) ? held[c] : gold[idx][c];
                checks++;
                if (result[c] !== exp) begin
                    errors++;
                    $display("FAIL b2b_result e=%0d c=%0d got=%0d exp=%0d", e, c, result[c], exp);
                end
            end
        end
        start = 1'b0;
        for (int c = 0; c < NC; c++) held[c] = gold[NV-1][c];
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        for (int v = 0; v < NV; v++) begin
            for (int c = 0; c < NC; c++) begin
                gold[v][c] = golden(v, c, 24);
            end
        end
        test_reset();
        test_run(1'b0);
        test_run(1'b1);
        test_mid_reset(17);
        test_run(1'b0);
        test_mid_reset($urandom_range(2, 19));
        test_run(1'b0);
        test_back_to_back();
        test_run(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_accel_top.md
# cnn_accel_top

Top level of the CNN accelerator: a weight-stationary systolic array (SYS_ROWS × SYS_COLS MACs) with on-chip weight and input ROMs and a control FSM. A single `start` pulse loads the weights and streams NUM_VEC input vectors. The block emits one dot-product vector `result[c] = Σr x[r]·W[r][c]` per cycle, flagged by `ready`. It is the integration point tested by the system bench.

## Interface
- SYS_ROWS, 6, array rows (input vector length)
- SYS_COLS, 3, array columns (output vector length)
- W_BITWIDTH, 8, unsigned weight width
- I_BITWIDTH, 8, unsigned input-activation width
- P_BITWIDTH, 24, unsigned partial-sum/result width
- NUM_VEC, 4, input vectors streamed per run
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  run request, sampled only in IDLE
- result  output  [SYS_COLS-1:0][P_BITWIDTH-1:0]  de-skewed output vector
- ready  output  1  result valid this cycle

## Operation
- Weight ROM: constant `W[r][c] = r+c+1`, truncated to W_BITWIDTH.
- Input ROM: constant `x_v[r] = v+r+1`, truncated to I_BITWIDTH.
- FSM states are IDLE, LOAD_W, STREAM and DRAIN.
  - IDLE → LOAD_W when start=1.
  - LOAD_W lasts SYS_ROWS cycles, then → STREAM.
  - STREAM lasts NUM_VEC cycles, then → DRAIN.
  - DRAIN → IDLE after the last result is presented.
- Weight load uses a shift-down chain.
  - On load edge k (k=0..SYS_ROWS-1), row 0 captures ROM row SYS_ROWS-1-k and every row r>0 captures row r-1.
  - After SYS_ROWS edges, PE row r holds W[r].
  - Weights are held until the next load.
- Streaming:
  - Element r of vector v enters row r delayed r cycles (input skew).
  - Activations move right one PE per cycle.
  - Partial sums move down one PE per cycle, starting from 0 at the top.
  - Column c output is delayed by (SYS_COLS-1-c) registers so all columns of one vector align.
- Arithmetic:
  - Products are W_BITWIDTH+I_BITWIDTH bits, zero-extended into P_BITWIDTH.
  - Accumulation is unsigned modulo 2^P_BITWIDTH (see Configuration).
- `start` outside IDLE is ignored. A new run reloads the weights.

## Timing
- Reset (asserted): FSM=IDLE; all PE weights, activations, partial sums and skew registers = 0; result=0; ready=0. Reset acts mid-run and aborts the run immediately.
- Cycle 0 is the edge sampling start=1 in IDLE. Load edges are 1..SYS_ROWS.
- Row 0 of vector v is injected at edge SYS_ROWS+1+v.
- Result for vector v is registered at edge T0+v, with T0 = 2·SYS_ROWS+SYS_COLS+1 (defaults: 16..19).
  - ready=1 exactly for those NUM_VEC consecutive cycles.
  - Vectors come out in order v=0..NUM_VEC-1.
- Return to IDLE at edge T0+NUM_VEC (defaults: 20).
  - result holds the last vector until the next run's first result or reset.
  - ready=0 outside result cycles.
- start held high continuously gives back-to-back runs separated by one IDLE cycle.

## Configuration
- Macro `CNN_ACC_SATURATE_EN`.
- Defined: every PE accumulation clamps to 2^P_BITWIDTH−1 on overflow, and a saturated partial sum stays saturated down the column.
- Undefined: accumulation wraps modulo 2^P_BITWIDTH.
- No interface or timing difference between the two builds.

## Test plan
- Reset only, start=0 for 30 cycles → ready=0, result=0 throughout, no state change.
- Defaults, start pulse at cycle 0:
  - ready high at edges 16..19.
  - v0 = {91,112,133}, v1 = {112,139,166} (c0,c1,c2).
  - v2 and v3 match the golden formula Σ(v+r+1)(r+c+1).
- Check PE weights after edge 6: row r, col c = r+c+1 (e.g. row 4 = {5,6,7}).
- start re-pulsed at cycle 8 (mid-run) → ignored, results identical to a single run.
- rst asserted at cycle 17 → ready and result 0 immediately. A new start after release gives the full correct sequence at T0 offsets.
- P_BITWIDTH=6: v0 c0 = 63 with CNN_ACC_SATURATE_EN defined, 27 without.
